mem_responder: RTL and testbench

//  Synthesizable memory-side responder for the ControlUnit memory port (addr/memory_w -> memory_ready).

---
 rtl/mem_responder_if.sv | 32 +++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - memory port bundle between initiator and mem_responder
//
// Purpose : groups the request/response signals of the memory port.
// Signals : addr         word address from initiator
//           memory_w     1 = write request, 0 = read
//           data_in      write data
//           data_out     registered read data
//           memory_ready 1 = idle/complete, 0 = busy
//           addr_err     out-of-range access flag
// Modports: master (initiator side), slave (responder side).

interface mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              memory_w;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              memory_ready;
    logic              addr_err;

    modport master (
        output addr, memory_w, data_in,
        input  data_out, memory_ready, addr_err
    );

    modport slave (
        input  addr, memory_w, data_in,
        output data_out, memory_ready, addr_err
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port RAM responder with configurable wait states
//
// Purpose : detects new requests on the memory port, holds memory_ready low
//           for READ_WAIT / WRITE_WAIT cycles, then commits the access to RAM
//           and raises memory_ready.
// Ports   : clk  rising-edge clock
//           rst  asynchronous active-high reset
//           mem  mem_responder_if.slave (addr, memory_w, data_in in;
//                data_out, memory_ready, addr_err out)
// Option  : MEM_RESPONDER_BOUNDS_EN - when defined, accesses with
//           addr >= 2**DEPTH_LOG2 suppress the write, read back 0 and set
//           addr_err; when undefined the address wraps and addr_err is 0.

module mem_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave mem
);

    if (READ_WAIT < 1 || READ_WAIT > 15 || WRITE_WAIT < 1 || WRITE_WAIT > 15) begin : g_bad_wait
        $error("mem_responder: READ_WAIT and WRITE_WAIT must be in 1..15");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic                prev_w_q;
    logic                w_q, w_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                ram_we;
    logic                trigger;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]   ram_rdata;

    logic [DATA_W-1:0]   ram_q [2**DEPTH_LOG2];

    assign idx       = last_addr_q[DEPTH_LOG2-1:0];
    assign ram_rdata = ram_q[idx];

    // A new request is an address change, or a rising memory_w so that
    // repeated writes to the same address are still recognised.
    assign trigger = (mem.addr != last_addr_q) || (mem.memory_w && !prev_w_q);

`ifdef MEM_RESPONDER_BOUNDS_EN
    logic in_range;
    logic addr_err_q, addr_err_d;
    assign in_range = ((last_addr_q >> DEPTH_LOG2) == '0);
`endif

    always_comb begin
        state_d     = state_q;
        last_addr_d = last_addr_q;
        w_d         = w_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        data_out_d  = data_out_q;
        ram_we      = 1'b0;
`ifdef MEM_RESPONDER_BOUNDS_EN
        addr_err_d  = addr_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    last_addr_d = mem.addr;
                    w_d         = mem.memory_w;
                    wdata_d     = mem.data_in;
                    ready_d     = 1'b0;
                    cnt_d       = mem.memory_w ? 4'(WRITE_WAIT - 1) : 4'(READ_WAIT - 1);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    state_d = IDLE;
`ifdef MEM_RESPONDER_BOUNDS_EN
                    addr_err_d = !in_range;
                    if (w_q) ram_we = in_range;
                    else     data_out_d = in_range ? ram_rdata : '0;
`else
                    if (w_q) ram_we = 1'b1;
                    else     data_out_d = ram_rdata;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_addr_q <= '0;
            prev_w_q    <= 1'b0;
            w_q         <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b1;
            data_out_q  <= '0;
`ifdef MEM_RESPONDER_BOUNDS_EN
            addr_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            prev_w_q    <= mem.memory_w;
            w_q         <= w_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            data_out_q  <= data_out_d;
`ifdef MEM_RESPONDER_BOUNDS_EN
            addr_err_q  <= addr_err_d;
`endif
        end
    end

    // RAM contents survive reset; a reset during BUSY forces IDLE so the
    // pending write never reaches this port.
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[idx] <= wdata_q;
    end

    assign mem.data_out     = data_out_q;
    assign mem.memory_ready = ready_q;
`ifdef MEM_RESPONDER_BOUNDS_EN
    assign mem.addr_err     = addr_err_q;
`else
    assign mem.addr_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed scoreboard bench for mem_responder

module tb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_responder #(
        .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .READ_WAIT(1), .WRITE_WAIT(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mem (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] model [0:1023];
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] expect_read(input logic [15:0] a);
`ifdef MEM_RESPONDER_BOUNDS_EN
        if (a >= 16'd1024) return 16'h0000;
`endif
        return model[a[9:0]];
    endfunction

    // Drive one request at a negedge and count negedges with ready low.
    task automatic txn(input string tag, input logic [15:0] a, input logic w,
                       input logic [15:0] d);
        int n_low;
        logic [15:0] e;
        @(negedge clk);
        bus.addr     = a;
        bus.memory_w = w;
        bus.data_in  = d;
        if (w) begin
`ifdef MEM_RESPONDER_BOUNDS_EN
            if (a < 16'd1024) model[a[9:0]] = d;
`else
            model[a[9:0]] = d;
`endif
        end else begin
            exp_q.push_back(expect_read(a));
        end
        n_low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.memory_ready === 1'b1) break;
            n_low++;
        end
        bus.memory_w = 1'b0;
        check({tag, "_wait"}, n_low, w ? 2 : 1);
        if (!w) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, bus.data_out, e);
        end
    endtask

    initial begin
        logic [15:0] e;
        bus.addr = '0; bus.memory_w = 1'b0; bus.data_in = '0;

        repeat (2) @(negedge clk);
        check("reset_ready", bus.memory_ready, 1);
        check("reset_data",  bus.data_out, 0);
        check("reset_err",   bus.addr_err, 0);
        rst = 1'b0;

        txn("w0",    16'h0000, 1'b1, 16'h5555);
        txn("w5",    16'h0005, 1'b1, 16'hBEEF);
        txn("w6",    16'h0006, 1'b1, 16'h6666);
        txn("r5",    16'h0005, 1'b0, 16'h0000);
        txn("r6",    16'h0006, 1'b0, 16'h0000);

        // Address changes while busy: 0x5 completes, 0x6 follows immediately.
        @(negedge clk);
        bus.addr = 16'h0005;
        exp_q.push_back(expect_read(16'h0005));
        exp_q.push_back(expect_read(16'h0006));
        @(negedge clk);
        check("chg_busy", bus.memory_ready, 0);
        bus.addr = 16'h0006;
        @(negedge clk);
        check("chg_done1", bus.memory_ready, 1);
        e = exp_q.pop_front();
        check("chg_data1", bus.data_out, e);
        @(negedge clk);
        check("chg_busy2", bus.memory_ready, 0);
        @(negedge clk);
        check("chg_done2", bus.memory_ready, 1);
        e = exp_q.pop_front();
        check("chg_data2", bus.data_out, e);

        // Two writes to the same address, each triggered by a memory_w rise.
        txn("w7a",   16'h0007, 1'b1, 16'h1111);
        txn("w7b",   16'h0007, 1'b1, 16'h2222);
        txn("r5b",   16'h0005, 1'b0, 16'h0000);
        txn("r7",    16'h0007, 1'b0, 16'h0000);

        // Same-address reread with memory_w low starts nothing.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reread_ready", bus.memory_ready, 1);
        end
        check("reread_data", bus.data_out, 16'h2222);

        // Reset one cycle into a write: write aborted, outputs cleared at once.
        txn("w10",   16'h0010, 1'b1, 16'h1010);
        @(negedge clk);
        bus.addr = 16'h0010; bus.memory_w = 1'b1; bus.data_in = 16'h1234;
        @(negedge clk);
        check("abort_busy", bus.memory_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("async_ready", bus.memory_ready, 1);
        check("async_data",  bus.data_out, 0);
        check("async_err",   bus.addr_err, 0);
        @(negedge clk);
        bus.memory_w = 1'b0; bus.addr = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        txn("r10",   16'h0010, 1'b0, 16'h0000);

        // Out-of-range write at 0x400.
        txn("w400",  16'h0400, 1'b1, 16'hAAAA);
`ifdef MEM_RESPONDER_BOUNDS_EN
        check("oob_err", bus.addr_err, 1);
`else
        check("oob_err", bus.addr_err, 0);
`endif
        txn("r0",    16'h0000, 1'b0, 16'h0000);
        check("r0_err", bus.addr_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
